// File: rtl/jtsimson_obj_draw.sv
// Object line drawer: fetches one 16-pixel 4bpp tile row from object ROM,
// then writes the zoomed, flipped, non-transparent pixels to the line buffer.
//
// Ports
//   rst, clk, cen       async active-high reset, clock, clock enable
//   dr_start/dr_busy    draw request from the table scanner / busy back
//   code..hz_keep       tile row description, latched on dr_start
//   rom_addr/cs/data/ok object ROM port, {code, ysub_eff, half}
//   buf_addr/din/we     object line buffer write port

module jtsimson_obj_draw #(
  parameter logic [9:0] HZ_ONE = 10'h40,
  parameter logic [9:0] HZ_MIN = 10'h04
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] code,
  input  logic [ 9:0] attr,
  input  logic [ 1:0] shd,
  input  logic [ 8:0] hpos,
  input  logic [ 3:0] ysub,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [ 9:0] hzoom,
  input  logic        hz_keep,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [ 8:0] buf_addr,
  output logic [15:0] buf_din,
  output logic        buf_we
);

  if (HZ_MIN == 10'd0 || HZ_MIN > HZ_ONE) begin : g_bad_hz
    $error("HZ_MIN must be nonzero and not above HZ_ONE");
  end

  typedef enum logic [1:0] {
    IDLE,
    FETCH0,
    FETCH1,
    DRAW
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] code_q, code_d;
  logic [ 3:0] ysub_q, ysub_d;
  logic [ 9:0] attr_q, attr_d;
  logic [ 1:0] shd_q, shd_d;
  logic        hflip_q, hflip_d;
  logic [ 9:0] hz_q, hz_d;
  logic [ 8:0] x_q, x_d;
  logic [ 9:0] src_q, src_d;
  logic [63:0] row_q, row_d;
  logic        skip_q, skip_d;
  logic        half_q, half_d;
  logic        cs_q, cs_d;
  logic        busy_q, busy_d;
  logic        we_q, we_d;
  logic [ 8:0] baddr_q, baddr_d;
  logic [15:0] bdin_q, bdin_d;

  logic [ 3:0] idx;
  logic [ 3:0] pxl;
  logic [10:0] sum;

  // Pixel n of the row sits at nibble 15-n, i.e. ~n.
  assign idx = src_q[9:6] ^ {4{hflip_q}};
  assign pxl = row_q[{~idx, 2'b00} +: 4];
  assign sum = {1'b0, src_q} + {1'b0, hz_q};

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ysub_d  = ysub_q;
    attr_d  = attr_q;
    shd_d   = shd_q;
    hflip_d = hflip_q;
    hz_d    = hz_q;
    x_d     = x_q;
    src_d   = src_q;
    row_d   = row_q;
    skip_d  = skip_q;
    half_d  = half_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    we_d    = 1'b0;
    baddr_d = baddr_q;
    bdin_d  = bdin_q;
    unique case (state_q)
      IDLE: begin
        if (dr_start) begin
          code_d  = code;
          ysub_d  = vflip ? ~ysub : ysub;
          attr_d  = attr;
          shd_d   = shd;
          hflip_d = hflip;
          hz_d    = (hzoom < HZ_MIN) ? HZ_MIN : hzoom;
          // With hz_keep the x/src left by the last
          // tile carry on, so zoomed objects stay seamless.
          if (!hz_keep) begin
            x_d   = hpos;
            src_d = 10'd0;
          end
          half_d  = 1'b0;
          skip_d  = 1'b1;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = FETCH0;
        end
      end
      FETCH0: begin
        // rom_ok still refers to the old address
        // on the first cen after a change.
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (rom_ok) begin
          row_d[63:32] = rom_data;
          half_d  = 1'b1;
          skip_d  = 1'b1;
          state_d = FETCH1;
        end
      end
      FETCH1: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (rom_ok) begin
          row_d[31:0] = rom_data;
          cs_d    = 1'b0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        we_d    = pxl != 4'd0;
        baddr_d = x_q;
        bdin_d  = {shd_q, attr_q, pxl};
        x_d     = x_q + 9'd1;
        src_d   = sum[9:0];
        if (sum[10]) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      ysub_q  <= '0;
      attr_q  <= '0;
      shd_q   <= '0;
      hflip_q <= 1'b0;
      hz_q    <= '0;
      x_q     <= '0;
      src_q   <= '0;
      row_q   <= '0;
      skip_q  <= 1'b0;
      half_q  <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= '0;
      bdin_q  <= '0;
    end else if (cen) begin
      state_q <= state_d;
      code_q  <= code_d;
      ysub_q  <= ysub_d;
      attr_q  <= attr_d;
      shd_q   <= shd_d;
      hflip_q <= hflip_d;
      hz_q    <= hz_d;
      x_q     <= x_d;
      src_q   <= src_d;
      row_q   <= row_d;
      skip_q  <= skip_d;
      half_q  <= half_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      bdin_q  <= bdin_d;
    end
  end

  assign dr_busy  = busy_q;
  assign rom_addr = {code_q, ysub_q, half_q};
  assign rom_cs   = cs_q;
  assign buf_addr = baddr_q;
  assign buf_din  = bdin_q;
  assign buf_we   = we_q;

endmodule

// File: tb/tb_jtsimson_obj_draw.sv
// Directed bench for jtsimson_obj_draw: ROM model with one clock of
// read latency, line-buffer write capture, hand-derived expectations.

module tb_jtsimson_obj_draw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        dr_start = 1'b0;
  logic        dr_busy;
  logic [15:0] code = '0;
  logic [ 9:0] attr = '0;
  logic [ 1:0] shd = '0;
  logic [ 8:0] hpos = '0;
  logic [ 3:0] ysub = '0;
  logic        hflip = 1'b0;
  logic        vflip = 1'b0;
  logic [ 9:0] hzoom = 10'h40;
  logic        hz_keep = 1'b0;
  logic [20:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data = '0;
  logic        rom_ok = 1'b1;
  logic [ 8:0] buf_addr;
  logic [15:0] buf_din;
  logic        buf_we;

  logic [63:0] tb_row = '0;
  logic        cen_alt = 1'b0;
  logic        cen_seen = 1'b0;
  int          n_err = 0;
  int          n_chk = 0;
  logic [ 8:0] cap_x[$];
  logic [15:0] cap_d[$];

  localparam logic [63:0] R0 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] R1 = 64'h1234_5678_9ABC_DEF1;

  jtsimson_obj_draw dut (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .dr_start (dr_start),
    .dr_busy  (dr_busy),
    .code     (code),
    .attr     (attr),
    .shd      (shd),
    .hpos     (hpos),
    .ysub     (ysub),
    .hflip    (hflip),
    .vflip    (vflip),
    .hzoom    (hzoom),
    .hz_keep  (hz_keep),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .buf_we   (buf_we)
  );

  always #5 clk = ~clk;

  always @(negedge clk) cen = cen_alt ? ~cen : 1'b1;

  always @(posedge clk) begin
    cen_seen <= cen;
    rom_data <= rom_addr[0] ? tb_row[31:0]
                            : tb_row[63:32];
  end

  always @(negedge clk) begin
    if (buf_we && cen_seen) begin
      cap_x.push_back(buf_addr);
      cap_d.push_back(buf_din);
    end
  end

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic start_tile(
    input logic [15:0] c, input logic [9:0] a,
    input logic [1:0] s, input logic [8:0] hp,
    input logic [3:0] ys, input logic hf,
    input logic vf, input logic [9:0] hz,
    input logic keep, input logic [63:0] r,
    input logic clr);
    if (clr) begin
      cap_x.delete();
      cap_d.delete();
    end
    code = c; attr = a; shd = s; hpos = hp;
    ysub = ys; hflip = hf; vflip = vf;
    hzoom = hz; hz_keep = keep; tb_row = r;
    dr_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      if (cen) break;
    end
    #1 dr_start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!dr_busy) break;
    end
    check({tag, " done"}, 32'(i < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Expected writes follow from walking the source
  // accumulator: one slot per step until it passes 1024.
  task automatic verify(string tag, int j0,
    input logic [8:0] hp, input int s0,
    input int hz, input logic [63:0] r,
    input logic hf, input logic [11:0] hi);
    int src, k, j, idx;
    logic [3:0] pix;
    src = s0; k = 0; j = j0;
    while (src < 1024) begin
      idx = (src >> 6) & 15;
      if (hf) idx = idx ^ 15;
      pix = r[(15 - idx) * 4 +: 4];
      if (pix != 4'd0) begin
        if (j < cap_x.size()) begin
          check($sformatf("%s x%0d", tag, j),
                32'(cap_x[j]), 32'((hp + k) & 9'h1FF));
          check($sformatf("%s din%0d", tag, j),
                32'(cap_d[j]), 32'({hi, pix}));
        end
        j++;
      end
      src += hz;
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(dr_busy), 0);
    check("rst cs", 32'(rom_cs), 0);
    check("rst addr", 32'(rom_addr), 0);
    check("rst we", 32'(buf_we), 0);
    check("rst baddr", 32'(buf_addr), 0);
    check("rst din", 32'(buf_din), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1:1, plus a dr_start pulse during DRAW
    start_tile(16'h1A2B, 10'h155, 2'd2, 9'h100, 4'h3,
               0, 0, 10'h40, 0, R0, 1);
    check("t1 busy", 32'(dr_busy), 1);
    check("t1 cs", 32'(rom_cs), 1);
    check("t1 addr", 32'(rom_addr),
          32'({16'h1A2B, 4'h3, 1'b0}));
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!rom_cs) break;
    end
    check("t1 fetch", 32'(i < 50), 1);
    @(posedge clk);
    #1 hpos = 9'h000; dr_start = 1'b1;
    @(posedge clk);
    #1 dr_start = 1'b0;
    wait_done("t1");
    check("t1 count", cap_x.size(), 15);
    verify("t1", 0, 9'h100, 0, 64, R0, 0,
           {2'd2, 10'h155});
    check("t1 cs end", 32'(rom_cs), 0);
    check("t1 busy end", 32'(dr_busy), 0);

    // hflip and vflip
    start_tile(16'h0777, 10'h2AA, 2'd1, 9'h100, 4'h3,
               1, 1, 10'h40, 0, R0, 1);
    check("t2 addr", 32'(rom_addr),
          32'({16'h0777, 4'hC, 1'b0}));
    wait_done("t2");
    check("t2 count", cap_x.size(), 15);
    verify("t2", 0, 9'h100, 0, 64, R0, 1,
           {2'd1, 10'h2AA});

    // enlarge 2x
    start_tile(16'h0001, 10'h001, 2'd0, 9'h010, 4'h0,
               0, 0, 10'h20, 0, R1, 1);
    wait_done("t3");
    check("t3 count", cap_x.size(), 32);
    verify("t3", 0, 9'h010, 0, 32, R1, 0,
           {2'd0, 10'h001});

    // shrink 2x
    start_tile(16'h0002, 10'h002, 2'd3, 9'h080, 4'h5,
               0, 0, 10'h80, 0, R1, 1);
    wait_done("t4");
    check("t4 count", cap_x.size(), 8);
    verify("t4", 0, 9'h080, 0, 128, R1, 0,
           {2'd3, 10'h002});

    // hzoom 0 clamps to 4
    start_tile(16'h0003, 10'h003, 2'd0, 9'h000, 4'h1,
               0, 0, 10'h00, 0, R1, 1);
    wait_done("t5");
    check("t5 count", cap_x.size(), 256);
    verify("t5", 0, 9'h000, 0, 4, R1, 0,
           {2'd0, 10'h003});

    // two tiles at 0x30, second continues x/src
    start_tile(16'h0004, 10'h004, 2'd0, 9'h040, 4'h2,
               0, 0, 10'h30, 0, R1, 1);
    wait_done("t6a");
    check("t6a count", cap_x.size(), 22);
    start_tile(16'h0005, 10'h004, 2'd0, 9'h1F0, 4'h2,
               0, 0, 10'h30, 1, R1, 0);
    wait_done("t6b");
    check("t6 count", cap_x.size(), 43);
    verify("t6a", 0, 9'h040, 0, 48, R1, 0,
           {2'd0, 10'h004});
    verify("t6b", 22, 9'h056, 32, 48, R1, 0,
           {2'd0, 10'h004});

    // x wraps past 0x1FF
    start_tile(16'h0006, 10'h006, 2'd1, 9'h1F8, 4'h0,
               0, 0, 10'h40, 0, R1, 1);
    wait_done("t7");
    check("t7 count", cap_x.size(), 16);
    verify("t7", 0, 9'h1F8, 0, 64, R1, 0,
           {2'd1, 10'h006});

    // cen at half rate
    cen_alt = 1'b1;
    start_tile(16'h0007, 10'h007, 2'd2, 9'h020, 4'h7,
               0, 0, 10'h40, 0, R0, 1);
    wait_done("t8");
    check("t8 count", cap_x.size(), 15);
    verify("t8", 0, 9'h020, 0, 64, R0, 0,
           {2'd2, 10'h007});
    @(negedge clk);
    wait (cen == 1'b1);
    cen_alt = 1'b0;
    @(posedge clk);
    #1;

    // reset while drawing
    start_tile(16'h0008, 10'h008, 2'd0, 9'h060, 4'h0,
               0, 0, 10'h20, 0, R1, 1);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cap_x.size() > 0) break;
    end
    check("t9 drawing", 32'(i < 50), 1);
    #2 rst = 1'b1;
    #1;
    check("t9 we", 32'(buf_we), 0);
    check("t9 busy", 32'(dr_busy), 0);
    check("t9 cs", 32'(rom_cs), 0);
    i = cap_x.size();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t9 no more", cap_x.size(), i);

    // hz_keep right after reset starts at x=0
    start_tile(16'h0009, 10'h009, 2'd0, 9'h050, 4'h0,
               0, 0, 10'h40, 1, R0, 1);
    wait_done("t10");
    check("t10 count", cap_x.size(), 15);
    verify("t10", 0, 9'h000, 0, 64, R0, 0,
           {2'd0, 10'h009});

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
